// File: rtl/loop_down_counter_if.sv
// loop_down_counter_if
//   Control/data bundle between a loop-control FSM (master) and the
//   loadable down-counter (slave).
//   Signals:
//     start     master->slave  load load_val and begin counting
//     stop      master->slave  abort counting
//     en        master->slave  decrement enable for the current cycle
//     load_val  master->slave  initial count, unsigned, DATAWIDTH bits
//     count     slave->master  current registered count (DEC input)
//     busy      slave->master  high while counting
//     done      slave->master  one-cycle pulse on terminal count
interface loop_down_counter_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic                 start;
  logic                 stop;
  logic                 en;
  logic [DATAWIDTH-1:0] load_val;
  logic [DATAWIDTH-1:0] count;
  logic                 busy;
  logic                 done;

  modport master (
    output start, stop, en, load_val,
    input  count, busy, done
  );

  modport slave (
    input  start, stop, en, load_val,
    output count, busy, done
  );
endinterface

// File: rtl/loop_down_counter.sv
// loop_down_counter
//   Loadable down-counter for datapath loop control. The registered count
//   feeds the decrementer (DEC) and the DEC result is fed back as the next
//   count. An IDLE/RUN/DONE FSM wraps the loop; all outputs are registered.
//   Ports:
//     clk   in  system clock, rising edge
//     rst   in  asynchronous, active-low reset
//     bus   loop_down_counter_if.slave (start, stop, en, load_val in;
//           count, busy, done out)
//   Configuration:
//     LOOP_CTR_RELOAD_EN  when defined, load_val is captured on start and the
//                         counter auto-reloads on terminal count, pulsing done
//                         every period and staying in RUN until stop.
module loop_down_counter #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  loop_down_counter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] count_q, count_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic [DATAWIDTH-1:0] dec_out;
  logic                 count_is_one;
  logic                 count_gt_one;

`ifdef LOOP_CTR_RELOAD_EN
  logic [DATAWIDTH-1:0] reload_q, reload_d;
`endif

  // DEC stage: only consumed when count > 1, so it never underflows.
  assign dec_out      = count_q - DATAWIDTH'(1);
  assign count_is_one = (count_q == DATAWIDTH'(1));
  assign count_gt_one = (count_q >  DATAWIDTH'(1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
`ifdef LOOP_CTR_RELOAD_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
`ifdef LOOP_CTR_RELOAD_EN
          reload_d = bus.load_val;
`endif
          if (bus.load_val != '0) begin
            count_d = bus.load_val;
            state_d = S_RUN;
          end else begin
            count_d = '0;
            state_d = S_DONE;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.en) begin
          if (count_gt_one) begin
            count_d = dec_out;
          end else if (count_is_one) begin
`ifdef LOOP_CTR_RELOAD_EN
            // Terminal count reloads and stays in RUN; done is pulsed here
            // rather than via the DONE state.
            count_d = reload_q;
            done_d  = 1'b1;
`else
            count_d = '0;
            state_d = S_DONE;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LOOP_CTR_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef LOOP_CTR_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_loop_down_counter.sv
module tb_loop_down_counter;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  loop_down_counter_if #(.DATAWIDTH(DW)) bus ();

  loop_down_counter #(.DATAWIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: a loop is either active or not; an active loop
  // holds a remaining-iterations value that counts down on enabled cycles.
  logic [DW-1:0] m_count;
  logic [DW-1:0] m_reload;
  bit            m_active;
  bit            m_done;

  task automatic model_reset();
    m_count  = '0;
    m_reload = '0;
    m_active = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit e, input logic [DW-1:0] lv);
    bit was_done;
    was_done = m_done;
    m_done   = 1'b0;
    if (!m_active) begin
      if (s) begin
        m_reload = lv;
        m_count  = lv;
        if (lv == 0) m_done = 1'b1;
        else         m_active = 1'b1;
      end
    end else if (p) begin
      m_active = 1'b0;
    end else if (e && m_count != 0) begin
      if (m_count == 1) begin
        m_done = 1'b1;
`ifdef LOOP_CTR_RELOAD_EN
        m_count = m_reload;
`else
        m_count  = 0;
        m_active = 1'b0;
`endif
      end else begin
        m_count = m_count - 1;
      end
    end
    if (was_done) begin end
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, settle.
  task automatic step(input bit s, input bit p, input bit e, input logic [DW-1:0] lv);
    bus.start    = s;
    bus.stop     = p;
    bus.en       = e;
    bus.load_val = lv;
    @(posedge clk);
    model_step(s, p, e, lv);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b0; bus.load_val = '0;
    rst = 1'b0;
    model_reset();
    #23;
    n_checks++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%0d busy=%b done=%b, required 0/0/0", bus.count, bus.busy, bus.done);
    end
    rst = 1'b1;
    step(0, 0, 1, 8'd9);
    n_checks++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: count=%0d busy=%b done=%b, required 0/0/0", bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_c [6];
    exp_c = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
`ifdef LOOP_CTR_RELOAD_EN
    exp_c[5] = 8'd5;
`endif
    step(1, 0, 1, 8'd5);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.count !== exp_c[i] || bus.done !== (i == 5) || bus.count !== m_count ||
          bus.busy !== m_active) begin
        n_fail++;
        $display("FAIL basic[%0d]: count=%0d done=%b busy=%b, required count=%0d done=%b busy=%b",
                 i, bus.count, bus.done, bus.busy, exp_c[i], (i == 5), m_active);
      end
      if (i < 5) step(0, 0, 1, 8'd0);
    end
    step(0, 1, 0, 8'd0);
    step(0, 0, 0, 8'd0);
  endtask

  task automatic test_gated();
    logic [DW-1:0] exp_c [6];
    bit            en_pat [5];
    exp_c  = '{8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0};
    en_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef LOOP_CTR_RELOAD_EN
    exp_c[5] = 8'd3;
`endif
    step(1, 0, 0, 8'd3);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.count !== exp_c[i] || bus.done !== (i == 5) || bus.busy !== m_active) begin
        n_fail++;
        $display("FAIL gated[%0d]: count=%0d done=%b busy=%b, required count=%0d done=%b busy=%b",
                 i, bus.count, bus.done, bus.busy, exp_c[i], (i == 5), m_active);
      end
      if (i < 5) step(0, 0, en_pat[i], 8'd0);
    end
    step(0, 1, 0, 8'd0);
    step(0, 0, 0, 8'd0);
  endtask

  task automatic test_zero_max();
    int done_at;
    step(1, 0, 1, 8'd0);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_load: done=%b busy=%b count=%0d, required 1/0/0", bus.done, bus.busy, bus.count);
    end
    step(0, 0, 1, 8'd0);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: done=%b busy=%b, required 0/0", bus.done, bus.busy);
    end
    step(1, 0, 1, 8'hFF);
    done_at = -1;
    for (int i = 1; i <= 260 && done_at < 0; i++) begin
      step(0, 0, 1, 8'd0);
      if (bus.done === 1'b1) done_at = i;
    end
    n_checks++;
    if (done_at != 255 || bus.count !== m_count) begin
      n_fail++;
      $display("FAIL max_load: done after %0d cycles count=%0d, required 255 cycles count=%0d",
               done_at, bus.count, m_count);
    end
    step(0, 1, 0, 8'd0);
    step(0, 0, 0, 8'd0);
  endtask

  task automatic test_abort_reset();
    step(1, 0, 0, 8'd10);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'd0);
    step(0, 1, 1, 8'd0);
    n_checks++;
    if (bus.count !== 8'd6 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: count=%0d busy=%b done=%b, required 6/0/0", bus.count, bus.busy, bus.done);
    end
    step(0, 1, 1, 8'd0);
    step(0, 0, 1, 8'd0);
    n_checks++;
    if (bus.count !== 8'd6 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold: count=%0d busy=%b done=%b, required 6/0/0", bus.count, bus.busy, bus.done);
    end
    step(1, 0, 0, 8'd10);
    step(0, 0, 1, 8'd0);
    step(0, 0, 1, 8'd0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: count=%0d busy=%b done=%b, required 0/0/0", bus.count, bus.busy, bus.done);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 8'd0);
    n_checks++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: count=%0d busy=%b done=%b, required 0/0/0", bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 1, 8'd0);
    step(1, 0, 1, 8'd2);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.count !== 8'd2 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start: busy=%b count=%0d done=%b, required 1/2/0", bus.busy, bus.count, bus.done);
    end
    step(0, 0, 1, 8'd0);
    step(0, 0, 1, 8'd0);
    n_checks++;
    if (bus.done !== 1'b1 || bus.count !== m_count || bus.busy !== m_active) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b count=%0d busy=%b, required 1/%0d/%b",
               bus.done, bus.count, bus.busy, m_count, m_active);
    end
    step(0, 1, 0, 8'd0);
    step(0, 0, 0, 8'd0);
  endtask

`ifdef LOOP_CTR_RELOAD_EN
  task automatic test_reload();
    logic [DW-1:0] exp_c;
    step(1, 0, 0, 8'd3);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 8'd0);
      exp_c = 8'(3 - ((i + 1) % 3));
      n_checks++;
      if (bus.count !== exp_c || bus.busy !== 1'b1 || bus.done !== (((i + 1) % 3) == 0)) begin
        n_fail++;
        $display("FAIL reload[%0d]: count=%0d busy=%b done=%b, required %0d/1/%b",
                 i, bus.count, bus.busy, bus.done, exp_c, (((i + 1) % 3) == 0));
      end
    end
    step(0, 1, 1, 8'd0);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 8'd2) begin
      n_fail++;
      $display("FAIL reload_stop: busy=%b done=%b count=%0d, required 0/0/2", bus.busy, bus.done, bus.count);
    end
  endtask
`endif

  task automatic test_random();
    bit            s, p, e;
    logic [DW-1:0] lv;
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      step(s, p, e, lv);
      n_checks++;
      if (bus.count !== m_count || bus.busy !== m_active || bus.done !== m_done) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d busy=%b done=%b, required %0d/%b/%b",
                 i, bus.count, bus.busy, bus.done, m_count, m_active, m_done);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_gated();
    test_zero_max();
    test_abort_reset();
    test_back_to_back();
`ifdef LOOP_CTR_RELOAD_EN
    test_reload();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
